// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: 16x oversample tick generator, FWFT RX FIFO,
// sticky overrun/framing flags, character timeout and interrupt output.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int DIV_W         = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          sck_rising_edge,
  input  logic                          rx_busy,
  input  logic                          rx_data_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_error,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          rx_timeout,
  input  logic                          clr_status,
  output logic                          irq
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  // ---------------------------------------------------------------------------
  // Tick generator state
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;

  // ---------------------------------------------------------------------------
  // Flags and timeout state
  // ---------------------------------------------------------------------------
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Handshake decode
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic overrun_set;

  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  // rd_valid is 0 when empty, so a push into an empty FIFO is never paired with a pop.
  assign do_pop      = rd_valid_q & rd_ready;
  // A full FIFO still accepts a byte if a slot is freed in the same cycle.
  assign do_push     = rx_data_valid & (~fifo_full | do_pop);
  assign overrun_set = rx_data_valid & fifo_full & ~do_pop;

  // Divider next state: the >= compare lets a lowered baud_div take effect at once.
  always_comb begin
    div_cnt_d = '0;
    tick_d    = 1'b0;
    if (enable) begin
      if (div_cnt_q >= baud_div) begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Divider registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  // FIFO pointer/occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rd_valid_d = (count_d != '0);
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // FIFO storage; contents need no reset because rd_data is masked while empty
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Sticky flags: a set event in the same cycle as clr_status wins
  always_comb begin
    overrun_d   = overrun_set | (overrun_q & ~clr_status);
    frame_err_d = (rx_data_valid & rx_error) | (frame_err_q & ~clr_status);
  end

  // Character timeout: count idle ticks while data waits, saturating at the limit
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rx_data_valid || do_pop || !rd_valid_q) begin
      to_cnt_d = '0;
    end else if (tick_q && !rx_busy && (to_cnt_q != TO_W'(TIMEOUT_TICKS))) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Flag and timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Outputs
  assign sck_rising_edge = tick_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_valid_q ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count      = count_q;
  assign overrun         = overrun_q;
  assign frame_err       = frame_err_q;
  assign rx_timeout      = (to_cnt_q == TO_W'(TIMEOUT_TICKS));
  assign irq             = rd_valid_q | overrun_q | frame_err_q | rx_timeout;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] baud_div;
  logic        sck_rising_edge;
  logic        rx_busy;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        rx_error;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        frame_err;
  logic        rx_timeout;
  logic        clr_status;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .DIV_W(16), .TIMEOUT_TICKS(640)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .baud_div       (baud_div),
    .sck_rising_edge(sck_rising_edge),
    .rx_busy        (rx_busy),
    .rx_data_valid  (rx_data_valid),
    .rx_data        (rx_data),
    .rx_error       (rx_error),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .fifo_count     (fifo_count),
    .overrun        (overrun),
    .frame_err      (frame_err),
    .rx_timeout     (rx_timeout),
    .clr_status     (clr_status),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_bytes [4];

    rst = 1'b1; enable = 1'b0; baud_div = 16'd3; rx_busy = 1'b0;
    rx_data_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    rd_ready = 1'b0; clr_status = 1'b0;
    step(); step();
    $display("reset: sck=%0d rd_valid=%0d count=%0d irq=%0d", sck_rising_edge, rd_valid, fifo_count, irq);
    chk("reset_sck", 32'(sck_rising_edge), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    // 1. baud_div=3: tick after every 4th edge
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      $display("div3 cycle %0d: sck=%0d", i, sck_rising_edge);
      chk("div3_tick", 32'(sck_rising_edge), (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      $display("disabled cycle %0d: sck=%0d", i, sck_rising_edge);
      chk("disabled_tick", 32'(sck_rising_edge), 32'd0);
    end

    // 2. baud_div 9 -> 2 while div_cnt=7
    baud_div = 16'd9; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("div9_no_tick", 32'(sck_rising_edge), 32'd0);
    end
    baud_div = 16'd2;
    for (int i = 0; i < 7; i++) begin
      step();
      $display("div9to2 cycle %0d: sck=%0d", i, sck_rising_edge);
      chk("div_lowered_tick", 32'(sck_rising_edge), (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    enable = 1'b0;
    step();

    // 3. Push A5, 3C then pop
    rx_data_valid = 1'b1; rx_data = 8'hA5; step();
    rx_data = 8'h3C; step();
    rx_data_valid = 1'b0;
    $display("push2: count=%0d rd_data=%02h", fifo_count, rd_data);
    chk("push2_count", 32'(fifo_count), 32'd2);
    chk("push2_head", 32'(rd_data), 32'h A5);
    chk("push2_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    $display("pop1: count=%0d rd_data=%02h", fifo_count, rd_data);
    chk("pop1_head", 32'(rd_data), 32'h3C);
    chk("pop1_count", 32'(fifo_count), 32'd1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("pop2_valid", 32'(rd_valid), 32'd0);
    chk("pop2_count", 32'(fifo_count), 32'd0);

    // 4a. Fill, then push 55 on full -> overrun, byte dropped
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    rx_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = exp_bytes[i]; step();
    end
    chk("fill_overrun_clear", 32'(overrun), 32'd0);
    rx_data = 8'h55; step();
    rx_data_valid = 1'b0;
    $display("overflow: count=%0d overrun=%0d head=%02h", fifo_count, overrun, rd_data);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_data", 32'(rd_data), 32'(exp_bytes[i]));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      $display("ovf drain %0d: count=%0d", i, fifo_count);
    end
    chk("ovf_drain_empty", 32'(rd_valid), 32'd0);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);

    // 4b. Full with simultaneous pop -> accepted, no overrun
    rx_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = exp_bytes[i]; step();
    end
    rx_data = 8'h66; rd_ready = 1'b1; step();
    rx_data_valid = 1'b0; rd_ready = 1'b0;
    $display("full+pop: count=%0d overrun=%0d head=%02h", fifo_count, overrun, rd_data);
    chk("fullpop_overrun", 32'(overrun), 32'd0);
    chk("fullpop_count", 32'(fifo_count), 32'd4);
    exp_bytes[0] = 8'h22; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h44; exp_bytes[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_drain_data", 32'(rd_data), 32'(exp_bytes[i]));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end
    chk("fullpop_empty", 32'(fifo_count), 32'd0);

    // 5. Error strobe with clr_status in same cycle -> set wins
    rx_data_valid = 1'b1; rx_data = 8'h77; rx_error = 1'b1; clr_status = 1'b1; step();
    rx_data_valid = 1'b0; rx_error = 1'b0;
    $display("err+clr: frame_err=%0d count=%0d head=%02h", frame_err, fifo_count, rd_data);
    chk("ferr_set_wins", 32'(frame_err), 32'd1);
    chk("ferr_byte_stored", 32'(rd_data), 32'h77);
    step();
    clr_status = 1'b0;
    chk("ferr_cleared", 32'(frame_err), 32'd0);
    chk("ferr_irq_valid", 32'(irq), 32'd1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("ferr_irq_empty", 32'(irq), 32'd0);

    // 6. Timeout with a tick every cycle
    baud_div = 16'd0; enable = 1'b1;
    step(); step();
    rx_data_valid = 1'b1; rx_data = 8'h9A; step();
    rx_data_valid = 1'b0;
    for (int i = 0; i < 639; i++) step();
    $display("timeout after 639: rx_timeout=%0d", rx_timeout);
    chk("to_before", 32'(rx_timeout), 32'd0);
    step();
    $display("timeout after 640: rx_timeout=%0d", rx_timeout);
    chk("to_reached", 32'(rx_timeout), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("to_saturated", 32'(rx_timeout), 32'd1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("to_pop_clear", 32'(rx_timeout), 32'd0);
    chk("to_pop_empty", 32'(rd_valid), 32'd0);

    // Reset mid-sequence drops all state
    rx_data_valid = 1'b1; rx_data = 8'hB1; rx_error = 1'b1; step();
    rx_data_valid = 1'b0; rx_error = 1'b0;
    chk("pre_rst_ferr", 32'(frame_err), 32'd1);
    rst = 1'b1; step();
    $display("mid reset: sck=%0d valid=%0d data=%02h count=%0d ovr=%0d ferr=%0d to=%0d irq=%0d",
             sck_rising_edge, rd_valid, rd_data, fifo_count, overrun, frame_err, rx_timeout, irq);
    chk("rst_sck", 32'(sck_rising_edge), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_timeout", 32'(rx_timeout), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
